// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC vectoring arbiter: default operand
// widths, FSM state encoding and the requester-index width helper.
package cordic_arb_pkg;

    localparam int DEF_INT_WIDTH   = 6;
    localparam int DEF_FRACT_WIDTH = 12;
    localparam int DEF_DATA_WIDTH  = DEF_INT_WIDTH + DEF_FRACT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Bits needed to index n requesters (never less than one bit).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own last-grant pointer. The search starts
// one position above the last winner and wraps, so a requester that keeps
// its request high cannot starve the others. The pointer only moves when
// advance_i is high and some request is present.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_i,
    input  logic           advance_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o,
    output logic           grant_valid_o
);

    logic [IDW-1:0] last_grant_q;
    logic [N-1:0]   mask_hi;
    logic [N-1:0]   req_hi;
    logic [N-1:0]   pick;
    logic [IDW-1:0] idx_chain [N+1];

    // Requesters strictly above the last winner get first chance.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign mask_hi[gi] = (IDW'(gi) > last_grant_q);
    end

    assign req_hi        = req_i & mask_hi;
    assign pick          = (req_hi != '0) ? req_hi : req_i;
    // Isolate the lowest set bit of the chosen vector.
    assign grant_o       = pick & (~pick + {{(N-1){1'b0}}, 1'b1});
    assign grant_valid_o = |req_i;

    // One-hot to binary encoder built as an OR chain.
    assign idx_chain[0] = '0;
    for (genvar gi = 0; gi < N; gi++) begin : g_enc
        assign idx_chain[gi+1] = idx_chain[gi] | (grant_o[gi] ? IDW'(gi) : '0);
    end
    assign grant_idx_o = idx_chain[N];

    // Pointer starts at N-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= IDW'(N - 1);
        end else if (advance_i && grant_valid_o) begin
            last_grant_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/cordic_vec_arbiter.sv
// Shares one vectoring CORDIC among NUM_REQ requesters. Grants one request
// at a time, latches its operands, runs the CORDIC enable/valid protocol
// (enable held until valid, then low for DRAIN_CYCLES) and returns the
// result with the owner's index over a valid/ready port.
// Optional watchdog: define CORDIC_ARB_TIMEOUT_EN to abort a RUN phase
// that sees no valid edge within TIMEOUT_CYCLES; the response then carries
// rsp_err_o=1 and zero results.
module cordic_vec_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int INT_WIDTH      = DEF_INT_WIDTH,
    parameter int FRACT_WIDTH    = DEF_FRACT_WIDTH,
    parameter int DATA_WIDTH     = INT_WIDTH + FRACT_WIDTH,
    parameter int ID_WIDTH       = id_width(NUM_REQ),
    parameter int DRAIN_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y_i,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic                          cordic_enable_o,
    output logic [DATA_WIDTH-1:0]         cordic_in1_o,
    output logic [DATA_WIDTH-1:0]         cordic_in2_o,
    input  logic                          cordic_valid_i,
    input  logic [DATA_WIDTH-1:0]         cordic_mag_i,
    input  logic [DATA_WIDTH-1:0]         cordic_angle_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_mag_o,
    output logic [DATA_WIDTH-1:0]         rsp_angle_o,
    output logic                          rsp_err_o,
    output logic                          busy_o
);

    localparam int DRAIN_W = 2;

    arb_state_e            state_q;
    logic [NUM_REQ-1:0]    req_ack_q;
    logic                  enable_q;
    logic [DATA_WIDTH-1:0] in1_q;
    logic [DATA_WIDTH-1:0] in2_q;
    logic                  rsp_valid_q;
    logic [ID_WIDTH-1:0]   rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_mag_q;
    logic [DATA_WIDTH-1:0] rsp_angle_q;
    logic                  busy_q;
    logic                  valid_prev_q;
    logic [DRAIN_W-1:0]    drain_cnt_q;

    logic [DATA_WIDTH-1:0] op_x [NUM_REQ];
    logic [DATA_WIDTH-1:0] op_y [NUM_REQ];
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  grant_valid;
    logic                  valid_rise;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
    logic            rsp_err_q;
    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Split the packed operand buses into per-requester slices.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
        assign op_x[gi] = req_x_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign op_y[gi] = req_y_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // The pointer advances only on the IDLE edge that actually grants.
    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_WIDTH)
    ) u_rr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .advance_i     (state_q == ST_IDLE),
        .grant_o       (grant_onehot),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // A completion is the first cycle valid is seen high.
    assign valid_rise = cordic_valid_i && !valid_prev_q;

    // Sequencer: grant, run the CORDIC, drain, then hold the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_ack_q    <= '0;
            enable_q     <= 1'b0;
            in1_q        <= '0;
            in2_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_mag_q    <= '0;
            rsp_angle_q  <= '0;
            busy_q       <= 1'b0;
            valid_prev_q <= 1'b0;
            drain_cnt_q  <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wdog_q       <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            valid_prev_q <= cordic_valid_i;
            req_ack_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        req_ack_q <= grant_onehot;
                        in1_q     <= op_x[grant_idx];
                        in2_q     <= op_y[grant_idx];
                        rsp_id_q  <= grant_idx;
                        enable_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        wdog_q    <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (valid_rise) begin
                        rsp_mag_q   <= cordic_mag_i;
                        rsp_angle_q <= cordic_angle_i;
                        enable_q    <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= ST_DRAIN;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_mag_q   <= '0;
                        rsp_angle_q <= '0;
                        rsp_err_q   <= 1'b1;
                        enable_q    <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
`ifdef CORDIC_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ack_o       = req_ack_q;
    assign cordic_enable_o = enable_q;
    assign cordic_in1_o    = in1_q;
    assign cordic_in2_o    = in2_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_id_o        = rsp_id_q;
    assign rsp_mag_o       = rsp_mag_q;
    assign rsp_angle_o     = rsp_angle_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// Directed bench for cordic_vec_arbiter with a 7-cycle CORDIC stand-in.
// The stand-in returns the reference result for the (-3.0, -0.5) vector
// and x+y / x-y for any other operands, so pass-through is checkable.
module tb_cordic_vec_arbiter;

    localparam int N   = 4;
    localparam int DW  = 18;
    localparam int LAT = 7;
    localparam int EXP_LAT = LAT + 1 + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [DW-1:0]   x_tab [N];
    logic [DW-1:0]   y_tab [N];
    logic [N*DW-1:0] req_x;
    logic [N*DW-1:0] req_y;
    logic [N-1:0]    req_ack;
    logic            cordic_enable;
    logic [DW-1:0]   cordic_in1;
    logic [DW-1:0]   cordic_in2;
    logic            cordic_valid = 1'b0;
    logic [DW-1:0]   cordic_mag = '0;
    logic [DW-1:0]   cordic_angle = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_mag;
    logic [DW-1:0]   rsp_angle;
    logic            rsp_err;
    logic            busy;

    logic            stuck = 1'b0;
    int              scnt = 0;
    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    assign req_x = {x_tab[3], x_tab[2], x_tab[1], x_tab[0]};
    assign req_y = {y_tab[3], y_tab[2], y_tab[1], y_tab[0]};

    cordic_vec_arbiter dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .req_x_i         (req_x),
        .req_y_i         (req_y),
        .req_ack_o       (req_ack),
        .cordic_enable_o (cordic_enable),
        .cordic_in1_o    (cordic_in1),
        .cordic_in2_o    (cordic_in2),
        .cordic_valid_i  (cordic_valid),
        .cordic_mag_i    (cordic_mag),
        .cordic_angle_i  (cordic_angle),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_id_o        (rsp_id),
        .rsp_mag_o       (rsp_mag),
        .rsp_angle_o     (rsp_angle),
        .rsp_err_o       (rsp_err),
        .busy_o          (busy)
    );

    function automatic logic [DW-1:0] ref_mag(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (x == 18'h3D000 && y == 18'h3F800) return 18'h030A6;
        return x + y;
    endfunction

    function automatic logic [DW-1:0] ref_angle(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (x == 18'h3D000 && y == 18'h3F800) return 18'h3D035;
        return x - y;
    endfunction

    // CORDIC stand-in: valid rises LAT cycles after enable, falls with enable.
    always @(posedge clk) begin
        if (!cordic_enable) begin
            cordic_valid <= 1'b0;
            scnt         <= 0;
        end else if (!stuck && !cordic_valid) begin
            if (scnt == LAT - 1) begin
                cordic_valid <= 1'b1;
                cordic_mag   <= ref_mag(cordic_in1, cordic_in2);
                cordic_angle <= ref_angle(cordic_in1, cordic_in2);
            end else begin
                scnt <= scnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for the grant pulse and checks it.
    task automatic wait_grant(input int id);
        int w = 0;
        while (req_ack === '0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("grant_onehot", 32'(req_ack), 32'(1 << id));
        check("grant_in1", 32'(cordic_in1), 32'(x_tab[id]));
        check("grant_in2", 32'(cordic_in2), 32'(y_tab[id]));
        check("grant_enable", 32'(cordic_enable), 32'd1);
        check("grant_busy", 32'(busy), 32'd1);
    endtask

    // Runs from the grant negedge through the response handshake.
    task automatic finish_txn(input int id, input int ready_delay,
                              input logic [N-1:0] raise_mask, input bit drop);
        int lat;
        logic [DW-1:0] em;
        logic [DW-1:0] ea;
        em = ref_mag(x_tab[id], y_tab[id]);
        ea = ref_angle(x_tab[id], y_tab[id]);
        if (drop) req = '0;
        @(negedge clk);
        check("ack_pulse_width", 32'(req_ack), 32'd0);
        check("run_enable", 32'(cordic_enable), 32'd1);
        req = req | raise_mask;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(EXP_LAT));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_mag", 32'(rsp_mag), 32'(em));
        check("rsp_angle", 32'(rsp_angle), 32'(ea));
        check("rsp_err", 32'(rsp_err), 32'd0);
        check("resp_enable", 32'(cordic_enable), 32'd0);
        $display("txn id=%0d mag=%05h angle=%05h err=%0d lat=%0d", rsp_id, rsp_mag, rsp_angle, rsp_err, lat);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_mag", 32'(rsp_mag), 32'(em));
            check("hold_ack", 32'(req_ack), 32'd0);
            check("hold_enable", 32'(cordic_enable), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_valid", 32'(rsp_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            x_tab[i] = 18'(32'h01000 * (i + 1));
            y_tab[i] = 18'(32'h00080 * (i + 1));
        end
        x_tab[0] = 18'h3D000;
        y_tab[0] = 18'h3F800;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_enable", 32'(cordic_enable), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: single requester 0, reference vector
        req = 4'b0001;
        wait_grant(0);
        finish_txn(0, 0, '0, 1'b1);

        // 3: stalled consumer while another request waits
        req = 4'b0010;
        wait_grant(1);
        finish_txn(1, 10, 4'b1000, 1'b1);
        wait_grant(3);
        finish_txn(3, 0, '0, 1'b1);

        // 4: request raised during RUN is served right after the handshake
        req = 4'b0001;
        wait_grant(0);
        finish_txn(0, 0, 4'b0100, 1'b1);
        @(negedge clk);
        check("late_req_grant", 32'(req_ack), 32'b0100);
        wait_grant(2);
        finish_txn(2, 0, '0, 1'b1);

        // 5: asynchronous reset during RUN
        req = 4'b1010;
        wait_grant(3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_enable", 32'(cordic_enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in1", 32'(cordic_in1), 32'd0);
        check("arst_rsp_id", 32'(rsp_id), 32'd0);
        check("arst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_grant(1);
        finish_txn(1, 0, '0, 1'b1);

        // 2: all requesters held high, fresh pointer
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            x_tab[i] = 18'(32'h01111 * (i + 1));
            y_tab[i] = 18'(32'h00101 * (i + 2));
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(k % N);
            finish_txn(k % N, 0, '0, k == 4);
        end

`ifdef CORDIC_ARB_TIMEOUT_EN
        // 6: watchdog abort with valid stuck low
        begin
            int lat;
            stuck = 1'b1;
            req = 4'b0001;
            wait_grant(0);
            req = '0;
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 300) begin
                @(negedge clk);
                lat++;
            end
            check("to_latency", 32'(lat), 32'd65);
            check("to_err", 32'(rsp_err), 32'd1);
            check("to_mag", 32'(rsp_mag), 32'd0);
            check("to_angle", 32'(rsp_angle), 32'd0);
            $display("txn id=%0d timeout err=%0d lat=%0d", rsp_id, rsp_err, lat);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("to_err_clear", 32'(rsp_err), 32'd0);
            stuck = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/cordic_vec_arbiter.md
Name: cordic_vec_arbiter

Overview:
Round-robin arbiter and sequencer that shares one external vector_cordic instance among NUM_REQ requesters. It grants one request at a time and latches that requester's (x, y) operands. It then drives the CORDIC enable/valid protocol, which requires enable held high until valid and then dropped. Finally it returns magnitude, angle and requester ID through a valid/ready response port. It sits between the channel-estimation front-ends and the single CORDIC datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INT_WIDTH, 6, integer bits of the Q-format operands
FRACT_WIDTH, 12, fractional bits
DATA_WIDTH, INT_WIDTH+FRACT_WIDTH, operand/result width (18)
ID_WIDTH, 2, width of requester index, at least clog2(NUM_REQ)
DRAIN_CYCLES, 1, cycles enable is held low after valid before the next operation (1..3)
TIMEOUT_CYCLES, 64, watchdog limit, used only with the optional feature

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request; held until the matching req_ack
req_x  in  NUM_REQ*DATA_WIDTH  packed signed x operands; slice i belongs to requester i
req_y  in  NUM_REQ*DATA_WIDTH  packed signed y operands
req_ack  out  NUM_REQ  one-cycle grant pulse; operands are captured on this edge
cordic_enable  out  1  to vector_cordic enable
cordic_in1  out  DATA_WIDTH  latched x to the CORDIC
cordic_in2  out  DATA_WIDTH  latched y to the CORDIC
cordic_valid  in  1  from the CORDIC
cordic_mag  in  DATA_WIDTH  CORDIC magnitude
cordic_angle  in  DATA_WIDTH  CORDIC angle
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts the result
rsp_id  out  ID_WIDTH  index of the requester that owns the result
rsp_mag  out  DATA_WIDTH  latched magnitude
rsp_angle  out  DATA_WIDTH  latched angle
rsp_err  out  1  result aborted by timeout; always 0 without the optional feature
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous and active-high:
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation abandons the transaction and emits no response.
- FSM states: IDLE, RUN, DRAIN, RESP. All outputs are registered.
- IDLE:
  - On an edge with req != 0, grant the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - On that edge: latch the winner's x and y into cordic_in1 and cordic_in2, set req_ack[winner]=1 for exactly one cycle, set rsp_id=winner, update last_grant, set cordic_enable=1, and go to RUN.
- RUN:
  - cordic_enable stays 1; cordic_in1 and cordic_in2 stay stable.
  - Valid is detected as a rising edge: cordic_valid=1 while the registered previous value is 0.
  - On detection: capture cordic_mag and cordic_angle into rsp_mag and rsp_angle, set cordic_enable=0, and go to DRAIN.
- DRAIN:
  - Count DRAIN_CYCLES with enable low, then go to RESP with rsp_valid=1.
- RESP:
  - rsp_valid, rsp_id, rsp_mag and rsp_angle are held until an edge where rsp_ready=1.
  - On that edge: rsp_valid goes to 0 and the FSM goes to IDLE.
  - Arbitration resumes in the cycle after the handshake; there is no overlap.
- Requests arriving while busy are not lost. The requester keeps req high and it is serviced in a later IDLE pass.
- The granted requester's req still high during the req_ack cycle does not cause a re-grant, because the FSM is already in RUN.
- Fairness: with all req bits held high, grants cycle 0,1,2,3,0,...
- Latency from grant to rsp_valid = CORDIC latency (enable to valid) + 1 (edge detect) + DRAIN_CYCLES.
- Arithmetic: pure pass-through; there is no rescaling or rounding of CORDIC results.

Optional Feature:
Macro CORDIC_ARB_TIMEOUT_EN.
- Defined: a watchdog counter runs in RUN. If it reaches TIMEOUT_CYCLES without a valid edge:
  - cordic_enable goes to 0.
  - rsp_mag and rsp_angle are set to 0 and rsp_err to 1.
  - The FSM goes to DRAIN and then RESP as normal.
  - rsp_err clears on the rsp_ready handshake.
- Undefined: no counter exists, rsp_err is tied to 0, and RUN waits indefinitely.

Decomposition:
- Package cordic_arb_pkg holds:
  - the FSM state encoding constants;
  - the default widths: INT_WIDTH, FRACT_WIDTH and DATA_WIDTH=18;
  - the ID_WIDTH function.
- One sub-module, rr_arbiter, is combinational plus the pointer register. Inputs are req and last_grant; outputs are a one-hot grant and a grant index. It is reused by other shared-resource blocks.

Test Plan:
1. Single requester 0 with x=0x3D000 (-3.0), y=0x3F800 (-0.5) on a 7-iteration CORDIC -> one req_ack[0] pulse, then rsp_valid with rsp_id=0, rsp_mag=0x030A6, rsp_angle=0x3D035 and rsp_err=0.
2. All four req held high, each with distinct operands -> grant order 0,1,2,3,0 and each rsp_id paired with its own operands' results.
3. rsp_ready held low for 10 cycles in RESP -> rsp_valid and the result stay stable for 10 cycles; no new req_ack; cordic_enable stays 0.
4. req[2] raised during RUN of requester 0 -> requester 2 is granted in the first IDLE edge after the handshake; its request is not dropped.
5. rst pulsed during RUN -> all outputs are 0 immediately (asynchronous); no rsp_valid; the next grant goes to the lowest set req bit.
6. With CORDIC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, cordic_valid stuck at 0 -> after 64 RUN cycles rsp_valid=1, rsp_err=1, rsp_mag=0 and rsp_angle=0.
